// File: rtl/flash_ctrl.sv
// Read-only memory-mapped SPI flash reader (mode 0, READ 0x03) with power-up wake (0xAB)
// and continuation of sequential word reads while chip-select stays asserted.
module flash_ctrl #(
  parameter int CLK_DIV      = 1,
  parameter int ADDR_BITS    = 24,
  parameter int IDLE_TIMEOUT = 32,
  parameter int POWERUP_WAIT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  localparam int WA      = ADDR_BITS - 2;
  localparam int MAX_A   = (POWERUP_WAIT > IDLE_TIMEOUT) ? POWERUP_WAIT : IDLE_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > 2 * CLK_DIV) ? MAX_A : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);

  typedef enum logic [3:0] {PWRUP, PWAIT, IDLE, CMD, ADDR, DATA, DONE, HOLD, GAP} state_t;

  state_t           r_state;
  logic             r_setup;
  logic             r_csn;
  logic             r_sck;
  logic             r_mosi;
  logic             r_ready;
  logic [31:0]      r_rdata;
  logic [31:0]      r_tx;
  logic [31:0]      r_rx;
  logic [5:0]       r_bit;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WA-1:0]    r_addr;

  logic             w_rd_req;
  logic             w_wr_req;
  logic [WA-1:0]    w_req_word;
  logic             w_shifting;
  logic             w_half_end;
  logic             w_last_bit;
  logic [5:0]       w_nbits;
  logic [31:0]      w_rx_next;
  logic [31:0]      w_word;
  logic [31:0]      w_addr_tx;
  logic             w_unused;

  assign w_rd_req   = sel_in & read_in & (write_mask_in == 4'b0000);
  assign w_wr_req   = sel_in & (write_mask_in != 4'b0000);
  assign w_req_word = address_in[ADDR_BITS-1:2];
  assign w_shifting = !r_setup && (r_state == PWRUP || r_state == CMD ||
                                   r_state == ADDR  || r_state == DATA);
  assign w_half_end = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last_bit = w_shifting && w_half_end && r_sck && (r_bit == w_nbits - 6'd1);
  assign w_rx_next  = {r_rx[30:0], flash_miso};
  // First byte off the wire is the least significant byte of the bus word.
  assign w_word     = {w_rx_next[7:0], w_rx_next[15:8], w_rx_next[23:16], w_rx_next[31:24]};
  assign w_addr_tx  = 32'({r_addr, 2'b00}) << (32 - ADDR_BITS);
  assign w_unused   = ^{write_value_in, address_in};

  always_comb begin
    w_nbits = 6'd8;
    if (r_state == ADDR) w_nbits = 6'(ADDR_BITS);
    else if (r_state == DATA) w_nbits = 6'd32;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PWRUP;
      r_setup <= 1'b1;
      r_csn   <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      // Bit engine: MOSI changes as SCK goes low, MISO captured as SCK goes low.
      if (w_shifting) begin
        if (w_half_end) begin
          r_div <= '0;
          if (!r_sck) begin
            r_sck <= 1'b1;
          end else begin
            r_sck  <= 1'b0;
            r_bit  <= r_bit + 6'd1;
            r_mosi <= r_tx[31];
            r_tx   <= {r_tx[30:0], 1'b0};
            if (r_state == DATA) r_rx <= w_rx_next;
          end
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
      case (r_state)
        PWRUP: begin
          if (r_csn) begin
            r_csn <= 1'b0;
          end else if (r_setup) begin
            r_setup <= 1'b0;
            r_mosi  <= 1'b1;
            r_tx    <= {8'hAB << 1, 24'h0};
            r_bit   <= '0;
            r_div   <= '0;
          end else if (w_last_bit) begin
            r_csn   <= 1'b1;
            r_mosi  <= 1'b0;
            r_cnt   <= '0;
            r_state <= PWAIT;
          end
        end
        PWAIT: begin
          if (r_cnt == CNT_W'(POWERUP_WAIT - 1)) r_state <= IDLE;
          else r_cnt <= r_cnt + CNT_W'(1);
        end
        IDLE: begin
          if (!r_ready && w_wr_req) begin
            r_ready <= 1'b1;
          end else if (!r_ready && w_rd_req) begin
            r_addr  <= w_req_word;
            r_csn   <= 1'b0;
            r_setup <= 1'b1;
            r_state <= CMD;
          end
        end
        CMD: begin
          if (r_setup) begin
            r_setup <= 1'b0;
            r_mosi  <= 1'b0;
            r_tx    <= {8'h03 << 1, 24'h0};
            r_bit   <= '0;
            r_div   <= '0;
          end else if (w_last_bit) begin
            r_mosi  <= w_addr_tx[31];
            r_tx    <= {w_addr_tx[30:0], 1'b0};
            r_bit   <= '0;
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (w_last_bit) begin
            r_mosi  <= 1'b0;
            r_tx    <= '0;
            r_bit   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_last_bit) begin
            // A requester that went away still advances the stream position.
            r_ready <= w_rd_req;
            r_rdata <= w_rd_req ? w_word : 32'h0;
            r_addr  <= r_addr + WA'(1);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= HOLD;
        end
        HOLD: begin
          if (!r_ready && w_wr_req) begin
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else if (!r_ready && w_rd_req) begin
            r_cnt <= '0;
            if (w_req_word == r_addr) begin
              r_mosi  <= 1'b0;
              r_tx    <= '0;
              r_bit   <= '0;
              r_div   <= '0;
              r_state <= DATA;
            end else begin
              r_csn   <= 1'b1;
              r_state <= GAP;
            end
          end else if (r_cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
            r_csn   <= 1'b1;
            r_cnt   <= '0;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (r_cnt == CNT_W'(2 * CLK_DIV - 1)) begin
            if (w_rd_req) begin
              r_addr  <= w_req_word;
              r_csn   <= 1'b0;
              r_setup <= 1'b1;
              r_state <= CMD;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= PWRUP;
      endcase
    end
  end

  assign read_value_out = r_rdata;
  assign ready_out      = r_ready;
  assign flash_clk      = r_sck;
  assign flash_csn      = r_csn;
  assign flash_mosi     = r_mosi;

endmodule

// File: tb/tb_flash_ctrl.sv
// Directed bench for flash_ctrl: behavioural SPI flash, bus driver and a
// scoreboard of expected read words / completion cycles.
module tb_flash_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = 32'hDEAD_BEEF;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        flash_clk;
  logic        flash_csn;
  logic        flash_mosi;
  logic        flash_miso = 1'b0;

  flash_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address_in(address_in), .sel_in(sel_in),
    .read_in(read_in), .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .read_value_out(read_value_out), .ready_out(ready_out), .flash_clk(flash_clk),
    .flash_csn(flash_csn), .flash_mosi(flash_mosi), .flash_miso(flash_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h required 0x%08h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Flash contents
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
  endfunction

  // SPI flash slave model
  int          s_bits = 0;
  logic [7:0]  s_cmd = '0;
  logic [23:0] s_addr = '0;
  int          sck_cnt = 0;
  logic [7:0]  cmd_log[$];
  logic [23:0] addr_log[$];

  always @(posedge flash_clk) sck_cnt++;

  always @(posedge flash_clk or posedge flash_csn) begin
    if (flash_csn) begin
      s_bits = 0;
      s_cmd  = '0;
      s_addr = '0;
    end else begin
      if (s_bits < 8) begin
        s_cmd = {s_cmd[6:0], flash_mosi};
        if (s_bits == 7) cmd_log.push_back(s_cmd);
      end else if (s_cmd == 8'h03 && s_bits < 32) begin
        s_addr = {s_addr[22:0], flash_mosi};
        if (s_bits == 31) addr_log.push_back(s_addr);
      end
      s_bits++;
    end
  end

  always @(negedge flash_clk) begin
    int k;
    logic [7:0] b;
    #1;
    if (!flash_csn && s_cmd == 8'h03 && s_bits >= 32) begin
      k = s_bits - 32;
      b = flash_byte(s_addr + 24'(k / 8));
      flash_miso = b[7 - (k % 8)];
    end
  end

  // Scoreboard and bus/pin monitor
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic prev_csn = 1'b1;
  int   rise_cyc = 0, fall_cyc = 0, rise_cnt = 0, last_ready = 0;

  always @(negedge clk) begin
    exp_t e;
    if (flash_csn !== prev_csn) begin
      if (flash_csn === 1'b1) begin
        rise_cyc = cyc;
        rise_cnt++;
      end else begin
        fall_cyc = cyc;
      end
      prev_csn = flash_csn;
    end
    if (ready_out === 1'b1) begin
      last_ready = cyc;
      if (sb.size() == 0) begin
        check("ready_without_request", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("read_value", read_value_out, e.data);
        check("ready_cycle", 32'(cyc), 32'(e.cyc));
        $display("txn: ready at cycle %0d data 0x%08h (expected cycle %0d data 0x%08h)",
                 cyc, read_value_out, e.cyc, e.data);
      end
    end else begin
      check("read_value_idle_zero", read_value_out, 32'h0);
    end
  end

  // Issue one bus request and hold it until ready_out; abs_cyc >= 0 overrides latency.
  task automatic bus_req(input logic [31:0] addr, input bit rd, input logic [3:0] mask,
                         input logic [31:0] exp_data, input int lat, input int abs_cyc);
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    address_in    = addr;
    sel_in        = 1'b1;
    read_in       = rd;
    write_mask_in = mask;
    e.data = exp_data;
    e.cyc  = (abs_cyc >= 0) ? abs_cyc : cyc + lat;
    sb.push_back(e);
    n = 0;
    while (ready_out !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("ready_timeout", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    #1;
    sel_in        = 1'b0;
    read_in       = 1'b0;
    write_mask_in = '0;
  endtask

  initial begin
    int r, sck0, rise0, ncmd;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_csn", 32'(flash_csn), 32'd1);
    check("reset_sck", 32'(flash_clk), 32'd0);
    check("reset_mosi", 32'(flash_mosi), 32'd0);
    check("reset_ready", 32'(ready_out), 32'd0);
    check("reset_rdata", read_value_out, 32'h0);

    // Power-up wake sequence with no requests
    reset_n = 1'b1;
    r = cyc;
    repeat (100) @(posedge clk);
    #1;
    check("pwrup_sck_pulses", 32'(sck_cnt), 32'd8);
    check("pwrup_cmd_count", 32'(cmd_log.size()), 32'd1);
    check("pwrup_cmd_ab", 32'(cmd_log[$]), 32'hAB);
    check("pwrup_csn_fall", 32'(fall_cyc), 32'(r + 1));
    check("pwrup_csn_rise", 32'(rise_cyc), 32'(r + 18));

    // Cold read from IDLE
    bus_req(32'h0000_0100, 1'b1, 4'h0, 32'h4433_2211, 130, -1);
    check("cold_cmd", 32'(cmd_log[$]), 32'h03);
    check("cold_addr", 32'(addr_log[$]), 32'h000100);

    // Sequential continuation
    rise0 = rise_cnt;
    ncmd  = cmd_log.size();
    bus_req(32'h0000_0104, 1'b1, 4'h0, flash_word(24'h000104), 65, -1);
    check("seq_csn_no_rise", 32'(rise_cnt), 32'(rise0));
    check("seq_no_cmd", 32'(cmd_log.size()), 32'(ncmd));

    // Non-sequential read from HOLD
    bus_req(32'h0000_0200, 1'b1, 4'h0, flash_word(24'h000200), 132, -1);
    check("nonseq_csn_rise", 32'(rise_cnt), 32'(rise0 + 1));
    check("nonseq_gap_len", 32'(fall_cyc - rise_cyc), 32'd2);
    check("nonseq_cmd", 32'(cmd_log[$]), 32'h03);
    check("nonseq_addr", 32'(addr_log[$]), 32'h000200);

    // HOLD idle timeout
    repeat (40) @(posedge clk);
    #1;
    check("timeout_csn_rise", 32'(rise_cyc), 32'(last_ready + 33));
    check("timeout_csn_high", 32'(flash_csn), 32'd1);

    // Write in IDLE
    sck0 = sck_cnt;
    bus_req(32'h0000_0100, 1'b0, 4'b0001, 32'h0, 1, -1);
    check("wr_idle_no_sck", 32'(sck_cnt), 32'(sck0));
    check("wr_idle_csn", 32'(flash_csn), 32'd1);

    // Write in HOLD (read strobe also set: write wins)
    bus_req(32'h0000_0300, 1'b1, 4'h0, flash_word(24'h000300), 130, -1);
    sck0  = sck_cnt;
    rise0 = rise_cnt;
    bus_req(32'h0000_0300, 1'b1, 4'b0001, 32'h0, 1, -1);
    check("wr_hold_no_sck", 32'(sck_cnt), 32'(sck0));
    check("wr_hold_csn_low", 32'(flash_csn), 32'd0);
    check("wr_hold_no_rise", 32'(rise_cnt), 32'(rise0));
    bus_req(32'h0000_0304, 1'b1, 4'h0, flash_word(24'h000304), 65, -1);

    // Asynchronous reset in the middle of a DATA phase
    @(posedge clk);
    #1;
    address_in = 32'h0000_0400;
    sel_in     = 1'b1;
    read_in    = 1'b1;
    repeat (90) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_csn", 32'(flash_csn), 32'd1);
    check("abort_sck", 32'(flash_clk), 32'd0);
    check("abort_ready", 32'(ready_out), 32'd0);
    sel_in  = 1'b0;
    read_in = 1'b0;
    sck0 = sck_cnt;
    ncmd = cmd_log.size();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    r = cyc;
    repeat (29) @(posedge clk);
    #1;
    check("rewake_sck_pulses", 32'(sck_cnt), 32'(sck0 + 8));
    check("rewake_cmd_ab", 32'(cmd_log[$]), 32'hAB);
    check("rewake_cmd_count", 32'(cmd_log.size()), 32'(ncmd + 1));

    // Read issued during PWAIT stalls; then wrap to address 0 as a continuation
    bus_req(32'h00FF_FFFC, 1'b1, 4'h0, flash_word(24'hFFFFFC), 0, r + 212);
    check("wrap_addr", 32'(addr_log[$]), 32'hFFFFFC);
    ncmd = cmd_log.size();
    rise0 = rise_cnt;
    bus_req(32'h0000_0000, 1'b1, 4'h0, flash_word(24'h000000), 65, -1);
    check("wrap_no_cmd", 32'(cmd_log.size()), 32'(ncmd));
    check("wrap_no_rise", 32'(rise_cnt), 32'(rise0));

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
